serial_addsub_nb: RTL and testbench
===================================

# serial_addsub_nb

Multi-cycle, digit-serial N-bit adder/subtractor, the parametrised successor to the team's fixed 4-bit ripple-carry adder. It processes a WIDTH-bit operand pair CHUNK bits per clock through a chained full-adder slice, carrying between chunks in a register. It exposes a start/busy/done handshake and returns sum, carry-out and signed overflow. It serves as the area-lean arithmetic unit for the datapath, where wide operands must not cost a full-width ripple chain.

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- CHUNK, 4, bits added per cycle; must divide WIDTH exactly. N = WIDTH/CHUNK.
- clk  in  1  rising-edge clock; the block uses one clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled on rising edge of clk.
- sub  in  1  0 = add, 1 = subtract; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- cin  in  1  carry-in (add) or borrow-in (subtract); captured with start.
- busy  out  1  high while the operation is in progress (RUN state).
- done  out  1  one-cycle pulse; result outputs are valid from this cycle.
- sum  out  WIDTH  result, registered.
- carry  out  1  carry-out of MSB (for subtract: 1 = no borrow).
- overflow  out  1  two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0 (busy, done, sum, carry, overflow).
- Accept: start=1 at an edge while in IDLE or DONE. At that edge, latch a, b, sub, and cin. Clear chunk index to 0. Load carry register with sub ? ~cin : cin. Go to RUN.
- start while in RUN is ignored; the latched operands are unaffected.
- Subtract: the B chunk is inverted before the adder slice. The result is a + ~b + ~cin = a − b − cin.
- RUN: each edge adds chunk j (bits j·CHUNK .. j·CHUNK+CHUNK−1) of A and of B (possibly inverted) plus the carry register. The chunk sum is written into the internal partial-result register, and the carry register takes the chunk's carry-out. j then increments.
- On the edge that completes chunk N−1:
  - sum ← full partial result.
  - carry ← final carry-out.
  - overflow ← (carry into MSB) XOR (carry out of MSB), both taken from the last chunk's slice.
  - State goes to DONE.
- DONE lasts exactly one cycle, with done=1 and busy=0. The next state is IDLE, or RUN if start=1 at that edge.
- sum, carry and overflow change only on completion edges and hold otherwise, including throughout a following RUN.
- Reset asserted mid-operation aborts immediately. The block returns to IDLE, all outputs clear, and the partial result is discarded.
- CHUNK = WIDTH is legal: N = 1, and the block degenerates to a single-cycle registered adder.

## Timing
- Start accepted at edge t0. busy=1 from t0 through edge t0+N. Chunk j commits at edge t0+j+1.
- done=1 and results valid from edge t0+N until edge t0+N+1. Latency from start to done is N cycles.
- Back-to-back throughput: one result per N+1 cycles when start is held through DONE. Restarting from DONE costs no extra cycle; restarting from IDLE adds one.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset is asynchronous assert. Deassertion is assumed synchronous to clk by the system.

## Test plan
- WIDTH=16, CHUNK=4, add 0xFFFF + 0x0001, cin=0 → sum=0x0000, carry=1, overflow=0. done pulses 4 cycles after the start edge; busy high for 4 cycles.
- Add 0x7FFF + 0x0001, cin=0 → sum=0x8000, carry=0, overflow=1. Add 0x1234 + 0x1111, cin=1 → sum=0x2346, carry=0, overflow=0.
- Subtract 0x8000 − 0x0001, cin=0 → sum=0x7FFF, carry=1, overflow=1. Subtract 0x0000 − 0x0001 → sum=0xFFFF, carry=0, overflow=0.
- Pulse start with new operands during RUN. → Ignored: result matches the first operands and only one done pulse occurs. Then hold start high through DONE. → The second operation begins with no idle cycle, and the first result holds until the second completes.
- Assert rst at cycle 2 of RUN. → busy, done, sum, carry and overflow are all 0 immediately. No done pulse follows; a fresh start afterward completes normally.
- WIDTH=8, CHUNK=8, add 0x80 + 0x80 → sum=0x00, carry=1, overflow=1, with done 1 cycle after start.

Source files
------------

// File: rtl/serial_addsub_nb.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_nb
// Description : Digit-serial WIDTH-bit adder/subtractor. Handles CHUNK bits
//               per clock through a chained full-adder slice. A register
//               carries between chunks. Completes in N = WIDTH/CHUNK cycles
//               and uses a start/busy/done handshake.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               start_i           - request (accepted in IDLE or DONE)
//               sub_i             - 0 = add, 1 = subtract (a - b - cin)
//               a_i, b_i          - operands
//               cin_i             - carry-in (add) / borrow-in (subtract)
//               busy_o            - operation in progress
//               done_o            - one-cycle completion pulse
//               sum_o             - registered result
//               carry_o           - carry-out of MSB (subtract: 1 = no borrow)
//               overflow_o        - two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_nb #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  part_q, part_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              sub_q, sub_d;
    logic              cy_q, cy_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    // Operands shift right one chunk per RUN cycle, so the slice always sees
    // the current chunk in the low CHUNK bits. The partial result fills from
    // the top. After N shifts it sits fully aligned.
    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK-1:0]  w_s;
    logic [CHUNK:0]    w_c;
    logic [WIDTH-1:0]  w_a_next;
    logic [WIDTH-1:0]  w_b_next;
    logic [WIDTH-1:0]  w_part_next;

    assign w_a_chunk = a_q[CHUNK-1:0];
    // Subtraction inverts B here. The carry register was preloaded with ~cin,
    // which gives a + ~b + ~cin = a - b - cin.
    assign w_b_chunk = b_q[CHUNK-1:0] ^ {CHUNK{sub_q}};
    assign w_c[0]    = cy_q;

    generate
        for (genvar k = 0; k < CHUNK; k++) begin : g_fa
            assign w_s[k]   = w_a_chunk[k] ^ w_b_chunk[k] ^ w_c[k];
            assign w_c[k+1] = (w_a_chunk[k] & w_b_chunk[k]) |
                              (w_c[k] & (w_a_chunk[k] ^ w_b_chunk[k]));
        end
    endgenerate

    generate
        if (N == 1) begin : g_single
            assign w_a_next    = a_q;
            assign w_b_next    = b_q;
            assign w_part_next = w_s;
        end else begin : g_multi
            assign w_a_next    = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
            assign w_b_next    = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
            assign w_part_next = {w_s, part_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        cy_d    = cy_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    a_d     = a_i;
                    b_d     = b_i;
                    sub_d   = sub_i;
                    cy_d    = sub_i ? ~cin_i : cin_i;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d    = w_a_next;
                b_d    = w_b_next;
                part_d = w_part_next;
                cy_d   = w_c[CHUNK];
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    sum_d   = w_part_next;
                    carry_d = w_c[CHUNK];
                    // Overflow: the carry into the sign bit differs from the
                    // carry out of it.
                    ovf_d   = w_c[CHUNK] ^ w_c[CHUNK-1];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            sub_q   <= 1'b0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o     = (state_q == S_RUN);
    assign done_o     = (state_q == S_DONE);
    assign sum_o      = sum_q;
    assign carry_o    = carry_q;
    assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_nb.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub_nb
// Description : Directed self-checking bench for serial_addsub_nb. Uses a
//               16/4 instance and a single-chunk 8/8 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_nb;

    logic        clk;
    logic        rst;
    logic        start, sub, cin;
    logic [15:0] a, b;
    logic        busy, done, carry, ovf;
    logic [15:0] sum;

    logic        start8, sub8, cin8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, carry8, ovf8;
    logic [7:0]  sum8;

    int total;
    int bad;

    serial_addsub_nb #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .sub_i(sub), .a_i(a), .b_i(b),
        .cin_i(cin), .busy_o(busy), .done_o(done), .sum_o(sum),
        .carry_o(carry), .overflow_o(ovf)
    );

    serial_addsub_nb #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .sub_i(sub8), .a_i(a8), .b_i(b8),
        .cin_i(cin8), .busy_o(busy8), .done_o(done8), .sum_o(sum8),
        .carry_o(carry8), .overflow_o(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done with a bound. Returns the number of edges waited.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            tick();
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [15:0] av,
                          input logic [15:0] bv, input logic c, input logic [15:0] es,
                          input logic ec, input logic ev);
        int cyc, bc;
        start = 1'b1; sub = s; a = av; b = bv; cin = c;
        tick();
        start = 1'b0;
        wait_done(cyc, bc);
        chk({tag, "_lat"},  cyc, 4);
        chk({tag, "_busy"}, bc, 4);
        chk({tag, "_bsy0"}, busy, 0);
        chk({tag, "_sum"},  sum, es);
        chk({tag, "_cy"},   carry, ec);
        chk({tag, "_ovf"},  ovf, ev);
        tick();
        chk({tag, "_dn1"},  done, 0);
    endtask

    initial begin
        int cyc, bc, dn;
        total = 0; bad = 0;
        rst = 1'b1;
        start = 0; sub = 0; cin = 0; a = '0; b = '0;
        start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum",  sum, 0);
        chk("rst_cy",   carry, 0);
        chk("rst_ovf",  ovf, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        run_op("add_ffff_1", 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
        run_op("add_7fff_1", 0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
        run_op("add_cin",    0, 16'h1234, 16'h1111, 1, 16'h2346, 0, 0);
        run_op("sub_8000_1", 1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1);
        run_op("sub_0_1",    1, 16'h0000, 16'h0001, 0, 16'hFFFF, 0, 0);

        // start pulsed during RUN must be ignored
        start = 1; sub = 0; a = 16'h0F0F; b = 16'h0101; cin = 0;
        tick();
        start = 0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                start = 1; sub = 1; a = 16'hFFFF; b = 16'hFFFF; cin = 1;
            end else begin
                start = 0;
            end
            if (done) begin
                dn++;
                chk("ign_sum", sum, 16'h1010);
                chk("ign_cy",  carry, 0);
            end
            tick();
        end
        chk("ign_dn_cnt", dn, 1);

        // back-to-back: start held through DONE
        start = 1; sub = 0; a = 16'h0001; b = 16'h0002; cin = 0;
        tick();
        a = 16'h0010; b = 16'h0020;
        wait_done(cyc, bc);
        chk("b2b_lat1", cyc, 4);
        chk("b2b_sum1", sum, 16'h0003);
        tick();
        start = 0;
        chk("b2b_busy", busy, 1);
        chk("b2b_hold", sum, 16'h0003);
        tick(); tick();
        chk("b2b_hold2", sum, 16'h0003);
        wait_done(cyc, bc);
        chk("b2b_lat2", cyc, 2);
        chk("b2b_sum2", sum, 16'h0030);
        tick();

        // reset mid-run
        start = 1; sub = 0; a = 16'h1111; b = 16'h2222; cin = 0;
        tick();
        start = 0;
        tick();
        rst = 1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_sum",  sum, 0);
        chk("mrst_cy",   carry, 0);
        chk("mrst_ovf",  ovf, 0);
        tick();
        rst = 0;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dn++;
            tick();
        end
        chk("mrst_nodone", dn, 0);
        run_op("post_rst", 0, 16'h1111, 16'h2222, 0, 16'h3333, 0, 0);

        // single-chunk instance
        start8 = 1; sub8 = 0; a8 = 8'h80; b8 = 8'h80; cin8 = 0;
        tick();
        start8 = 0;
        chk("w8_busy", busy8, 1);
        chk("w8_done0", done8, 0);
        tick();
        chk("w8_done", done8, 1);
        chk("w8_sum",  sum8, 8'h00);
        chk("w8_cy",   carry8, 1);
        chk("w8_ovf",  ovf8, 1);
        tick();
        chk("w8_done1", done8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
